// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM state type and sizing helper for the restoring divider.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/divider_if.sv
// rtl/divider_if.sv - operand and result handshakes of the divider.
interface divider_if #(
  parameter int widthn = 32,
  parameter int widthd = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [widthn-1:0] dividend;
  logic [widthd-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [widthn-1:0] quotient;
  logic [widthd-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division iteration.
module divider_step #(
  parameter int widthd = 16
) (
  input  logic [widthd:0]   rem,
  input  logic              bit_in,
  input  logic [widthd-1:0] divisor,
  output logic [widthd:0]   rem_next,
  output logic              q_bit
);
  logic [widthd+1:0] shifted;
  logic [widthd+1:0] diff;
  logic              unused_msb;

  // A borrow out of the top bit means the trial subtraction failed: keep the shifted value.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[widthd+1];
    rem_next = q_bit ? diff[widthd:0] : shifted[widthd:0];
  end

  assign unused_msb = shifted[widthd+1];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative restoring divider, one quotient bit per enabled cycle.
module divider
  import divider_pkg::*;
#(
  parameter int widthn = 32,
  parameter int widthd = 16,
  parameter bit us     = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clken,
  divider_if.slave  bus
);
  localparam int cw = clog2(widthn);

  state_t            state;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [widthn-1:0] quotient_r;
  logic [widthd-1:0] remainder_r;
  logic              div_by_zero_r;

  logic [widthn-1:0] n_raw;
  logic [widthd-1:0] d_raw;
  logic              sign_n;
  logic              sign_d;
  logic              zero_div;
  logic [widthd-1:0] d_mag_r;
  logic [widthn-1:0] shreg;
  logic [widthd:0]   prem;
  logic [cw-1:0]     cnt;

  logic              n_neg;
  logic              d_neg;
  logic [widthn-1:0] n_mag;
  logic [widthd-1:0] d_mag;
  logic [widthd:0]   rem_next;
  logic              q_bit;
  logic [widthn-1:0] q_fix;
  logic [widthd-1:0] r_fix;

  // Magnitudes are read as unsigned, so the most negative value maps to 2**(w-1) correctly.
  always_comb begin
    n_neg = (us == 1'b0) && n_raw[widthn-1];
    d_neg = (us == 1'b0) && d_raw[widthd-1];
    n_mag = n_neg ? -n_raw : n_raw;
    d_mag = d_neg ? -d_raw : d_raw;
    q_fix = (sign_n ^ sign_d) ? -shreg : shreg;
    r_fix = sign_n ? -prem[widthd-1:0] : prem[widthd-1:0];
  end

  divider_step #(.widthd(widthd)) u_step (
    .rem      (prem),
    .bit_in   (shreg[widthn-1]),
    .divisor  (d_mag_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
      n_raw         <= '0;
      d_raw         <= '0;
      sign_n        <= 1'b0;
      sign_d        <= 1'b0;
      zero_div      <= 1'b0;
      d_mag_r       <= '0;
      shreg         <= '0;
      prem          <= '0;
      cnt           <= '0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            n_raw      <= bus.dividend;
            d_raw      <= bus.divisor;
            in_ready_r <= 1'b0;
            state      <= PREP;
          end
        end
        PREP: begin
          sign_n   <= n_neg;
          sign_d   <= d_neg;
          d_mag_r  <= d_mag;
          shreg    <= n_mag;
          prem     <= '0;
          cnt      <= cw'(widthn - 1);
          zero_div <= (d_raw == '0);
          state    <= (d_raw == '0) ? FIX : CALC;
        end
        CALC: begin
          shreg <= {shreg[widthn-2:0], q_bit};
          prem  <= rem_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            quotient_r    <= '1;
            remainder_r   <= n_raw[widthd-1:0];
            div_by_zero_r <= 1'b1;
          end else begin
            quotient_r    <= q_fix;
            remainder_r   <= r_fix;
            div_by_zero_r <= 1'b0;
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // Return to IDLE only; the next pair is taken on a later cycle.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - vector table, random model comparison and stall/reset sequences for divider.
module tb_divider;

  logic clk;
  logic reset;
  logic clken;
  int   n_tests;
  int   n_fail;

  divider_if #(.widthn(32), .widthd(16)) uif ();
  divider_if #(.widthn(32), .widthd(16)) sif ();

  divider #(.widthn(32), .widthd(16), .us(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .bus   (uif.slave)
  );

  divider #(.widthn(32), .widthd(16), .us(1'b0)) s_dut (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [31:0] n;
    logic [15:0] d;
    logic [31:0] q;
    logic [15:0] r;
    bit          dz;
    int          lat;
    int          hold;
    bit          stall;
  } vec_t;

  vec_t vecs[$];

  function automatic logic get_in_ready(input bit sel);
    return sel ? uif.in_ready : sif.in_ready;
  endfunction
  function automatic logic get_out_valid(input bit sel);
    return sel ? uif.out_valid : sif.out_valid;
  endfunction
  function automatic logic [31:0] get_q(input bit sel);
    return sel ? uif.quotient : sif.quotient;
  endfunction
  function automatic logic [15:0] get_r(input bit sel);
    return sel ? uif.remainder : sif.remainder;
  endfunction
  function automatic logic get_dz(input bit sel);
    return sel ? uif.div_by_zero : sif.div_by_zero;
  endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [31:0] n, input logic [15:0] d);
    if (sel) begin
      uif.in_valid = v; uif.dividend = n; uif.divisor = d;
    end else begin
      sif.in_valid = v; sif.dividend = n; sif.divisor = d;
    end
  endtask

  task automatic set_out_ready(input bit sel, input logic v);
    if (sel) uif.out_ready = v;
    else     sif.out_ready = v;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: plain truncating division on wide integers; the 64-bit range absorbs MIN/-1.
  function automatic void model(input bit sel, input logic [31:0] n, input logic [15:0] d,
                                output logic [31:0] q, output logic [15:0] r, output bit dz);
    longint sn, sd, lq, lr;
    if (d == 16'h0) begin
      q  = 32'hFFFF_FFFF;
      r  = n[15:0];
      dz = 1'b1;
      return;
    end
    if (sel) begin
      sn = longint'({32'h0, n});
      sd = longint'({48'h0, d});
    end else begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
    end
    lq = sn / sd;
    lr = sn % sd;
    q  = lq[31:0];
    r  = lr[15:0];
    dz = 1'b0;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int guard;
    int lat;
    @(negedge clk);
    clken = 1'b1;
    drive_in(v.sel, 1'b1, v.n, v.d);
    guard = 0;
    while (!get_in_ready(v.sel) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      timeout({tag, "_accept"});
      drive_in(v.sel, 1'b0, 32'h0, 16'h0);
      return;
    end
    @(negedge clk);
    drive_in(v.sel, 1'b0, $urandom, 16'($urandom));
    lat = 0;
    guard = 0;
    while (!get_out_valid(v.sel) && guard < 1000) begin
      if (v.stall) clken = 1'($urandom_range(0, 1));
      if (clken) lat++;
      @(negedge clk);
      guard++;
    end
    clken = 1'b1;
    if (guard >= 1000) begin
      timeout({tag, "_done"});
      return;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_quotient"}, 64'(get_q(v.sel)), 64'(v.q));
    check({tag, "_remainder"}, 64'(get_r(v.sel)), 64'(v.r));
    check({tag, "_div_by_zero"}, 64'(get_dz(v.sel)), 64'(v.dz));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(get_out_valid(v.sel)), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(get_in_ready(v.sel)), 64'd0);
      check({tag, "_hold_quotient"}, 64'(get_q(v.sel)), 64'(v.q));
      check({tag, "_hold_remainder"}, 64'(get_r(v.sel)), 64'(v.r));
    end
    set_out_ready(v.sel, 1'b1);
    @(negedge clk);
    set_out_ready(v.sel, 1'b0);
    check({tag, "_post_in_ready"}, 64'(get_in_ready(v.sel)), 64'd1);
    check({tag, "_post_out_valid"}, 64'(get_out_valid(v.sel)), 64'd0);
  endtask

  task automatic add_vec(input bit sel, input logic [31:0] n, input logic [15:0] d,
                         input logic [31:0] q, input logic [15:0] r, input bit dz,
                         input int lat, input int hold, input bit stall);
    vec_t v;
    v.sel = sel; v.n = n; v.d = d; v.q = q; v.r = r; v.dz = dz;
    v.lat = lat; v.hold = hold; v.stall = stall;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [31:0] mq;
    logic [15:0] mr;
    bit          mdz;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    clken = 1'b1;
    drive_in(1'b1, 1'b0, 32'h0, 16'h0);
    drive_in(1'b0, 1'b0, 32'h0, 16'h0);
    set_out_ready(1'b1, 1'b0);
    set_out_ready(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_in_ready", 64'(get_in_ready(s[0])), 64'd1);
      check("reset_out_valid", 64'(get_out_valid(s[0])), 64'd0);
      check("reset_quotient", 64'(get_q(s[0])), 64'd0);
      check("reset_remainder", 64'(get_r(s[0])), 64'd0);
      check("reset_div_by_zero", 64'(get_dz(s[0])), 64'd0);
    end
    reset = 1'b0;

    //      sel   dividend       divisor   quotient       remainder dz lat hold stall
    add_vec(1'b1, 32'd1000,      16'd7,    32'd142,       16'd6,    0, 34, 10, 0);
    add_vec(1'b0, 32'hFFFFFFF9,  16'd2,    32'hFFFFFFFD,  16'hFFFF, 0, 34, 0,  0);
    add_vec(1'b0, 32'd7,         16'hFFFE, 32'hFFFFFFFD,  16'd1,    0, 34, 0,  0);
    add_vec(1'b0, 32'hFFFFFFF9,  16'hFFFE, 32'd3,         16'hFFFF, 0, 34, 0,  0);
    add_vec(1'b1, 32'h12345678,  16'h0,    32'hFFFFFFFF,  16'h5678, 1, 2,  0,  0);
    add_vec(1'b0, 32'h12345678,  16'h0,    32'hFFFFFFFF,  16'h5678, 1, 2,  3,  0);
    add_vec(1'b0, 32'h80000000,  16'hFFFF, 32'h80000000,  16'h0,    0, 34, 0,  0);
    add_vec(1'b0, 32'h80000000,  16'h8000, 32'h00010000,  16'h0,    0, 34, 0,  0);
    add_vec(1'b1, 32'hFFFFFFFF,  16'd1,    32'hFFFFFFFF,  16'h0,    0, 34, 0,  0);
    add_vec(1'b1, 32'd5,         16'hFFFF, 32'd0,         16'd5,    0, 34, 0,  0);
    add_vec(1'b1, 32'd0,         16'd5,    32'd0,         16'd0,    0, 34, 0,  0);
    add_vec(1'b1, 32'd1000,      16'd7,    32'd142,       16'd6,    0, 34, 0,  1);
    add_vec(1'b0, 32'hFFFFFC18,  16'd7,    32'hFFFFFF72,  16'hFFFA, 0, 34, 0,  1);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.n   = $urandom;
      case ($urandom_range(0, 4))
        0:       v.d = 16'h0;
        1:       v.d = 16'($urandom_range(1, 3));
        2:       v.d = 16'hFFFF;
        default: v.d = 16'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) v.n = 32'h80000000;
      model(v.sel, v.n, v.d, mq, mr, mdz);
      v.q = mq; v.r = mr; v.dz = mdz;
      v.lat   = mdz ? 2 : 34;
      v.hold  = $urandom_range(0, 2);
      v.stall = ((i % 3) == 0);
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Abort a unsigned operation mid-CALC; nothing from it may ever surface.
    @(negedge clk);
    drive_in(1'b1, 1'b1, 32'd1000, 16'd7);
    @(negedge clk);
    drive_in(1'b1, 1'b0, 32'h0, 16'h0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_in_ready", 64'(uif.in_ready), 64'd1);
    check("midreset_out_valid", 64'(uif.out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset_no_output", 64'(uif.out_valid), 64'd0);
    v.sel = 1'b1; v.n = 32'd100; v.d = 16'd10; v.q = 32'd10; v.r = 16'd0;
    v.dz = 1'b0; v.lat = 34; v.hold = 0; v.stall = 1'b0;
    run_op(v, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
